// File: rtl/axi4_write_command_issuer.sv
// axi4_write_command_issuer: queues divider burst commands, issues them on AW,
// hands burst lengths to the data mover and tracks outstanding B responses.
module axi4_write_command_issuer #(
   parameter int AddressWidth   = 32,
   parameter int DataWidth      = 32,
   parameter int QueueDepth     = 8,
   parameter int IssueThreshold = 4,
   parameter int MaxOutstanding = 8
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [AddressWidth-1:0] DIVADDR,
   input  logic [7:0]              DIVLEN,
   input  logic                    DIVVALID,
   output logic                    DIVREADY,
   input  logic                    DIVFLUSH,
   output logic [AddressWidth-1:0] M_AWADDR,
   output logic [7:0]              M_AWLEN,
   output logic [2:0]              M_AWSIZE,
   output logic [1:0]              M_AWBURST,
   output logic                    M_AWVALID,
   input  logic                    M_AWREADY,
   output logic [7:0]              WLEN,
   output logic                    WLENVALID,
   input  logic                    WLENREADY,
   input  logic                    M_BVALID,
   input  logic [1:0]              M_BRESP,
   output logic                    M_BREADY,
   output logic                    BUSY,
   output logic                    ERROR
);
   localparam int PW = $clog2(QueueDepth);
   localparam int CW = PW + 1;
   localparam int OW = $clog2(MaxOutstanding) + 1;
   localparam logic [CW-1:0] QD  = CW'(QueueDepth);
   localparam logic [CW-1:0] THR = CW'(IssueThreshold);
   localparam logic [OW-1:0] MO  = OW'(MaxOutstanding);

   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state_q;

   logic [AddressWidth-1:0] cmd_addr_q [QueueDepth];
   logic [7:0]              cmd_len_q  [QueueDepth];
   logic [7:0]              len_mem_q  [QueueDepth];
   logic [PW-1:0]           cmd_wr_q, cmd_rd_q, len_wr_q, len_rd_q;
   logic [CW-1:0]           cmd_cnt_q, cmd_cnt_d, len_cnt_q, len_cnt_d;
   logic [OW-1:0]           out_q, out_d;
   logic [AddressWidth-1:0] awaddr_q;
   logic [7:0]              awlen_q;
   logic                    awvalid_q, error_q;
   logic                    cmd_push, issue, aw_hs, len_pop, b_hs;

   assign DIVREADY  = (cmd_cnt_q < QD) && ARESETN;
   assign WLENVALID = (len_cnt_q != '0) && ARESETN;
   assign WLEN      = WLENVALID ? len_mem_q[len_rd_q] : 8'd0;
   assign M_BREADY  = (out_q != '0) && ARESETN;
   assign BUSY      = ARESETN && (cmd_cnt_q != '0 || len_cnt_q != '0 || awvalid_q || out_q != '0);
   assign ERROR     = error_q;
   assign M_AWADDR  = awaddr_q;
   assign M_AWLEN   = awlen_q;
   assign M_AWVALID = awvalid_q;
   assign M_AWSIZE  = 3'($clog2(DataWidth / 8));
   assign M_AWBURST = 2'b01;

   always_comb begin
      cmd_push  = DIVVALID && DIVREADY;
      aw_hs     = awvalid_q && M_AWREADY;
      len_pop   = WLENVALID && WLENREADY;
      b_hs      = M_BVALID && M_BREADY;
      // Room in the length queue is reserved up front so the AW handshake can always push.
      issue     = state_q == IDLE && cmd_cnt_q != '0 && (cmd_cnt_q >= THR || DIVFLUSH) &&
                  out_q < MO && len_cnt_q < QD;
      cmd_cnt_d = cmd_cnt_q + CW'(cmd_push) - CW'(issue);
      len_cnt_d = len_cnt_q + CW'(aw_hs) - CW'(len_pop);
      out_d     = out_q + OW'(aw_hs) - OW'(b_hs);
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q   <= IDLE;
         cmd_wr_q  <= '0;
         cmd_rd_q  <= '0;
         cmd_cnt_q <= '0;
         len_wr_q  <= '0;
         len_rd_q  <= '0;
         len_cnt_q <= '0;
         out_q     <= '0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         awvalid_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         if (cmd_push) begin
            cmd_addr_q[cmd_wr_q] <= DIVADDR;
            cmd_len_q[cmd_wr_q]  <= DIVLEN;
            cmd_wr_q             <= cmd_wr_q + 1'b1;
         end
         if (issue) begin
            awaddr_q  <= cmd_addr_q[cmd_rd_q];
            awlen_q   <= cmd_len_q[cmd_rd_q];
            cmd_rd_q  <= cmd_rd_q + 1'b1;
            awvalid_q <= 1'b1;
            state_q   <= ISSUE;
         end else if (aw_hs) begin
            awvalid_q <= 1'b0;
            state_q   <= IDLE;
         end
         if (aw_hs) begin
            len_mem_q[len_wr_q] <= awlen_q;
            len_wr_q            <= len_wr_q + 1'b1;
         end
         if (len_pop) len_rd_q <= len_rd_q + 1'b1;
         if (b_hs && M_BRESP[1]) error_q <= 1'b1;
         cmd_cnt_q <= cmd_cnt_d;
         len_cnt_q <= len_cnt_d;
         out_q     <= out_d;
      end
   end
endmodule
